// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op encodings, FSM states and
// status-flag bit positions.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_SHL   = 4'b0010;
   localparam logic [3:0] OP_SHR   = 4'b0011;
   localparam logic [3:0] OP_CMP   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_NAND  = 4'b1000;
   localparam logic [3:0] OP_NOR   = 4'b1001;
   localparam logic [3:0] OP_XNOR  = 4'b1010;
   localparam logic [3:0] OP_NOT   = 4'b1011;
   localparam logic [3:0] OP_NEG   = 4'b1100;
   localparam logic [3:0] OP_STORE = 4'b1101;
   localparam logic [3:0] OP_MUL   = 4'b1110;
   localparam logic [3:0] OP_ZERO  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int FLAG_CARRY = 0;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_NEG   = 2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// 'done' is high during the cycle whose rising edge completes the final
// iteration; 'product' then already shows the finished 2*WIDTH result.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               trigger,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;
   logic               busy;

   // Partial-product accumulation for the current multiplier bit.
   always_comb begin
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end
   end

   assign done    = busy && (count == CW'(1));
   assign product = acc_next;

   // Operand capture on start, then shift multiplicand left / multiplier right.
   always_ff @(posedge trigger or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         acc    <= '0;
         mplier <= b;
         count  <= CW'(WIDTH);
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
         if (count == CW'(1)) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU top: single-cycle logic/arith ops plus an optional
// iterative multiplier. Define ALU_MUL_EN to build the multiplier; without
// it op 1110 behaves like op 1111 and BUSY is never entered.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             trigger,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_hi,
   output logic             out_valid,
   output logic             carry,
   output logic             zero,
   output logic             neg
);

   state_t           state;
   state_t           next_state;
   logic [2:0]       flags;
   logic [WIDTH-1:0] res;
   logic             res_carry;
   logic [WIDTH:0]   sum;
   logic             accept;
   logic             is_mul;
   logic             mul_done;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign sum       = {1'b0, A} + {1'b0, B};

   assign carry = flags[FLAG_CARRY];
   assign zero  = flags[FLAG_ZERO];
   assign neg   = flags[FLAG_NEG];

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] mul_product;

   assign is_mul = (op == OP_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .trigger (trigger),
      .reset   (reset),
      .start   (accept && is_mul),
      .a       (A),
      .b       (B),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign is_mul   = 1'b0;
   assign mul_done = 1'b0;
`endif

   // Single-cycle result and carry for the presented op.
   always_comb begin
      res       = '0;
      res_carry = 1'b0;
      case (op)
         OP_ADD: begin
            res       = sum[WIDTH-1:0];
            res_carry = sum[WIDTH];
         end
         OP_SUB: begin
            res       = B - A;
            res_carry = (A > B);
         end
         OP_SHL: begin
            res       = A << 1;
            res_carry = A[WIDTH-1];
         end
         OP_SHR: begin
            res       = A >> 1;
            res_carry = A[0];
         end
         OP_CMP: begin
            if (A == B)     res = '0;
            else if (A > B) res = WIDTH'(1);
            else            res = {WIDTH{1'b1}};
         end
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_XOR:  res = A ^ B;
         OP_NAND: res = ~(A & B);
         OP_NOR:  res = ~(A | B);
         OP_XNOR: res = ~(A ^ B);
         OP_NOT:  res = ~A;
         OP_NEG:  res = '0 - A;
         default: res = '0;
      endcase
   end

   // Result/flag registers: loaded on single-cycle accept or MUL completion,
   // otherwise held (STORE deliberately leaves them untouched).
   always_ff @(posedge trigger or posedge reset) begin
      if (reset) begin
         Y     <= '0;
         Y_hi  <= '0;
         flags <= 3'b000;
         flags[FLAG_ZERO] <= 1'b1;
      end else if (accept && !is_mul && (op != OP_STORE)) begin
         Y                 <= res;
         Y_hi              <= '0;
         flags[FLAG_CARRY] <= res_carry;
         flags[FLAG_ZERO]  <= (res == '0);
         flags[FLAG_NEG]   <= res[WIDTH-1];
      end
`ifdef ALU_MUL_EN
      else if ((state == BUSY) && mul_done) begin
         Y                 <= mul_product[WIDTH-1:0];
         Y_hi              <= mul_product[2*WIDTH-1:WIDTH];
         flags[FLAG_CARRY] <= 1'b0;
         flags[FLAG_ZERO]  <= (mul_product == '0);
         flags[FLAG_NEG]   <= mul_product[2*WIDTH-1];
      end
`endif
   end

   // FSM state register.
   always_ff @(posedge trigger or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state: accept leads to DONE (or BUSY for MUL), DONE returns to IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = is_mul ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (mul_done) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: table-driven single-cycle vectors on
// a WIDTH=8 instance, hand sequences for STORE, MUL, reset abort and a
// WIDTH=16 instance for shift/wrap behaviour.
module tb_alu_multicycle;
   import alu_pkg::*;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic       c;
      logic       z;
      logic       n;
   } vector_t;

   logic        trigger;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [7:0]  aSig;
   logic [7:0]  bSig;
   logic [3:0]  opSig;
   logic [7:0]  ySig;
   logic [7:0]  yHi;
   logic        outValid;
   logic        carrySig;
   logic        zeroSig;
   logic        negSig;

   logic        inValid16;
   logic        inReady16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic [3:0]  op16;
   logic [15:0] y16;
   logic [15:0] yHi16;
   logic        outValid16;
   logic        carry16;
   logic        zero16;
   logic        neg16;

   int          checks;
   int          errors;
   vector_t     vectors[20];

   alu_multicycle #(.WIDTH(8)) dut (
      .trigger   (trigger),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .A         (aSig),
      .B         (bSig),
      .op        (opSig),
      .Y         (ySig),
      .Y_hi      (yHi),
      .out_valid (outValid),
      .carry     (carrySig),
      .zero      (zeroSig),
      .neg       (negSig)
   );

   alu_multicycle #(.WIDTH(16)) dut16 (
      .trigger   (trigger),
      .reset     (reset),
      .in_valid  (inValid16),
      .in_ready  (inReady16),
      .A         (a16),
      .B         (b16),
      .op        (op16),
      .Y         (y16),
      .Y_hi      (yHi16),
      .out_valid (outValid16),
      .carry     (carry16),
      .zero      (zero16),
      .neg       (neg16)
   );

   // Free-running clock.
   initial begin
      trigger = 1'b0;
      forever #5 trigger = ~trigger;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Present one op to the WIDTH=8 instance; returns #1 after the accept edge.
   task automatic applyStimulus(input logic [3:0] opIn, input logic [7:0] aIn,
                                input logic [7:0] bIn);
      int waitCount;
      waitCount = 0;
      @(negedge trigger);
      while (!inReady && waitCount < 20) begin
         @(negedge trigger);
         waitCount++;
      end
      checkOutput("in_ready before accept", {31'd0, inReady}, 32'd1);
      inValid = 1'b1;
      opSig   = opIn;
      aSig    = aIn;
      bSig    = bIn;
      @(posedge trigger);
      #1;
      inValid = 1'b0;
   endtask

   task automatic checkResult(input string tag, input logic [7:0] y, input logic [7:0] yh,
                              input logic c, input logic z, input logic n);
      checkOutput({tag, ".Y"},         {24'd0, ySig}, {24'd0, y});
      checkOutput({tag, ".Y_hi"},      {24'd0, yHi},  {24'd0, yh});
      checkOutput({tag, ".carry"},     {31'd0, carrySig}, {31'd0, c});
      checkOutput({tag, ".zero"},      {31'd0, zeroSig},  {31'd0, z});
      checkOutput({tag, ".neg"},       {31'd0, negSig},   {31'd0, n});
      checkOutput({tag, ".out_valid"}, {31'd0, outValid}, 32'd1);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".Y"},         {24'd0, ySig}, 32'd0);
      checkOutput({tag, ".Y_hi"},      {24'd0, yHi},  32'd0);
      checkOutput({tag, ".carry"},     {31'd0, carrySig}, 32'd0);
      checkOutput({tag, ".zero"},      {31'd0, zeroSig},  32'd1);
      checkOutput({tag, ".neg"},       {31'd0, negSig},   32'd0);
      checkOutput({tag, ".out_valid"}, {31'd0, outValid}, 32'd0);
      checkOutput({tag, ".in_ready"},  {31'd0, inReady},  32'd1);
   endtask

   initial begin
      logic sawPulse;
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      inValid   = 1'b0;
      aSig      = '0;
      bSig      = '0;
      opSig     = '0;
      inValid16 = 1'b0;
      a16       = '0;
      b16       = '0;
      op16      = '0;

      vectors[0]  = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
      vectors[1]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0};
      vectors[2]  = '{OP_SUB,  8'h03, 8'h0A, 8'h07, 1'b0, 1'b0, 1'b0};
      vectors[3]  = '{OP_SUB,  8'h0A, 8'h03, 8'hF9, 1'b1, 1'b0, 1'b1};
      vectors[4]  = '{OP_CMP,  8'h03, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b1};
      vectors[5]  = '{OP_CMP,  8'h09, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0};
      vectors[6]  = '{OP_CMP,  8'h04, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0};
      vectors[7]  = '{OP_SHL,  8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0};
      vectors[8]  = '{OP_SHR,  8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0};
      vectors[9]  = '{OP_AND,  8'hAA, 8'h0F, 8'h0A, 1'b0, 1'b0, 1'b0};
      vectors[10] = '{OP_OR,   8'hAA, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b1};
      vectors[11] = '{OP_NAND, 8'hAA, 8'h0F, 8'hF5, 1'b0, 1'b0, 1'b1};
      vectors[12] = '{OP_NOR,  8'hAA, 8'h0F, 8'h50, 1'b0, 1'b0, 1'b0};
      vectors[13] = '{OP_XNOR, 8'hAA, 8'h0F, 8'h5A, 1'b0, 1'b0, 1'b0};
      vectors[14] = '{OP_NOT,  8'hFF, 8'h12, 8'h00, 1'b0, 1'b1, 1'b0};
      vectors[15] = '{OP_NEG,  8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
      vectors[16] = '{OP_NEG,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      vectors[17] = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
      vectors[18] = '{OP_ZERO, 8'h55, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0};
      vectors[19] = '{OP_XOR,  8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0, 1'b1};

      // Reset state before any clock edge.
      #2;
      checkResetState("reset0");
      checkOutput("reset0.Y16", {16'd0, y16}, 32'd0);
      checkOutput("reset0.zero16", {31'd0, zero16}, 32'd1);
      @(negedge trigger);
      reset = 1'b0;

      // Single-cycle table: result visible with out_valid right after accept,
      // and the pulse lasts exactly one cycle.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b);
         checkResult($sformatf("vec%0d", i), vectors[i].y, 8'h00,
                     vectors[i].c, vectors[i].z, vectors[i].n);
         @(posedge trigger);
         #1;
         checkOutput($sformatf("vec%0d.pulse_end", i), {31'd0, outValid}, 32'd0);
      end

      // STORE after XOR keeps Y/flags and still pulses out_valid.
      applyStimulus(OP_STORE, 8'h12, 8'h34);
      checkResult("store_after_xor", 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);

      // STORE keeps a set carry and zero flag too.
      applyStimulus(OP_ADD, 8'hFF, 8'h01);
      checkResult("add_wrap", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      applyStimulus(OP_STORE, 8'h01, 8'h01);
      checkResult("store_after_add", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

`ifdef ALU_MUL_EN
      // MUL 0xFF*0xFF = 0xFE01, result appears WIDTH+1 cycles after accept;
      // inputs presented during BUSY are ignored.
      applyStimulus(OP_MUL, 8'hFF, 8'hFF);
      inValid = 1'b1;
      opSig   = OP_ADD;
      aSig    = 8'h00;
      bSig    = 8'h00;
      for (int k = 1; k <= 8; k++) begin
         if (k < 8) begin
            checkOutput($sformatf("mul.busy%0d.out_valid", k), {31'd0, outValid}, 32'd0);
            checkOutput($sformatf("mul.busy%0d.in_ready", k), {31'd0, inReady}, 32'd0);
            checkOutput($sformatf("mul.busy%0d.Y_hold", k), {24'd0, ySig}, 32'd0);
         end
         @(posedge trigger);
         #1;
      end
      inValid = 1'b0;
      checkResult("mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1);
      @(posedge trigger);
      #1;
      checkOutput("mul.pulse_end", {31'd0, outValid}, 32'd0);
      checkOutput("mul.Y_after", {24'd0, ySig}, 32'h01);
      applyStimulus(OP_ADD, 8'h02, 8'h03);
      checkResult("add_after_mul", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a MUL aborts it.
      applyStimulus(OP_MUL, 8'h0F, 8'h03);
      repeat (3) @(posedge trigger);
      #1;
`else
      // Op 1110 without the multiplier: single cycle, Y=0, BUSY never entered.
      applyStimulus(OP_MUL, 8'h05, 8'h03);
      checkResult("mul_disabled", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      @(posedge trigger);
      #1;
      checkOutput("mul_disabled.in_ready", {31'd0, inReady}, 32'd1);

      // Reset with non-reset values showing.
      applyStimulus(OP_ADD, 8'h40, 8'h41);
      checkResult("pre_reset_add", 8'h81, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
      reset = 1'b1;
      #1;
      checkResetState("async_reset");
      @(negedge trigger);
      reset    = 1'b0;
      sawPulse = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge trigger);
         #1;
         if (outValid) sawPulse = 1'b1;
      end
      checkOutput("no_pulse_after_abort", {31'd0, sawPulse}, 32'd0);
      applyStimulus(OP_ADD, 8'h01, 8'h01);
      checkResult("add_after_reset", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);

      // WIDTH=16 instance: shift-left carry and add wrap-around.
      for (int k = 0; k < 2; k++) begin
         @(negedge trigger);
         inValid16 = 1'b1;
         op16      = (k == 0) ? OP_SHL : OP_ADD;
         a16       = (k == 0) ? 16'h8001 : 16'hFFFF;
         b16       = (k == 0) ? 16'h0000 : 16'h0001;
         @(posedge trigger);
         #1;
         inValid16 = 1'b0;
         checkOutput($sformatf("w16_%0d.Y", k), {16'd0, y16}, (k == 0) ? 32'h0002 : 32'h0000);
         checkOutput($sformatf("w16_%0d.carry", k), {31'd0, carry16}, 32'd1);
         checkOutput($sformatf("w16_%0d.zero", k), {31'd0, zero16}, (k == 0) ? 32'd0 : 32'd1);
         checkOutput($sformatf("w16_%0d.out_valid", k), {31'd0, outValid16}, 32'd1);
         @(posedge trigger);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL have port trigger, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operands and op presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept a new operation.
REQ-006 SHALL have ports A and B, input, WIDTH, unsigned operands.
REQ-007 SHALL have port op, input, 4, operation selector.
REQ-008 SHALL have port Y, output, WIDTH, registered result (low half for MUL).
REQ-009 SHALL have port Y_hi, output, WIDTH, high half of MUL product; 0 after any other op.
REQ-010 SHALL have port out_valid, output, 1, one-cycle pulse marking new Y/Y_hi/flags.
REQ-011 SHALL have ports carry, zero, neg, output, 1 each, registered status flags.

Function
REQ-012 SHALL accept an operation on a trigger edge where in_valid and in_ready are both 1.
REQ-013 SHALL implement op encodings: 0000 A+B; 0001 B-A; 0010 A<<1; 0011 A>>1; 0100 compare; 0101 AND; 0110 OR; 0111 XOR; 1000 NAND; 1001 NOR; 1010 XNOR; 1011 NOT A; 1100 -A (two's complement); 1101 STORE; 1110 MUL; 1111 result 0.
REQ-014 SHALL produce compare result 0 if A==B, 1 if A>B, all-ones if A<B (unsigned).
REQ-015 SHALL truncate all single-cycle results to WIDTH bits (wrap-around).
REQ-016 SHALL set carry: ADD carry-out; SUB 1 when A>B (borrow); SHL A[WIDTH-1]; SHR A[0]; otherwise 0.
REQ-017 SHALL set zero when WIDTH-bit Y==0 (for MUL: full 2*WIDTH product==0) and neg = Y[WIDTH-1] (for MUL: Y_hi[WIDTH-1]).
REQ-018 SHALL use states IDLE, BUSY, DONE; IDLE->DONE on single-cycle accept, IDLE->BUSY on MUL accept, BUSY->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-019 SHALL update Y/Y_hi/flags on the accept edge for single-cycle ops, assert out_valid in DONE: latency 1 cycle after accept.
REQ-020 SHALL compute MUL as unsigned shift-add, one bit per cycle, out_valid exactly WIDTH+1 cycles after accept.
REQ-021 SHALL drive in_ready=1 only in IDLE; in_valid during BUSY/DONE is ignored, not queued.
REQ-022 SHALL, for STORE, leave Y, Y_hi and flags unchanged yet still pulse out_valid.
REQ-023 SHALL hold Y/Y_hi/flags stable between out_valid pulses, including during BUSY.
REQ-024 SHALL capture A and B at accept; operand changes during BUSY have no effect.

Reset
REQ-025 SHALL on reset force state IDLE, Y=0, Y_hi=0, carry=0, zero=1, neg=0, out_valid=0, in_ready=1 immediately, independent of trigger.
REQ-026 SHALL abort an in-flight MUL on reset with no out_valid pulse; first accept after reset release behaves normally.

Configuration
REQ-027 SHALL honour macro ALU_MUL_EN: defined -> MUL per REQ-020; undefined -> op 1110 treated as 1111 (single-cycle, Y=0, Y_hi=0), BUSY never entered, multiplier logic absent.

Structure
REQ-028 SHALL place op encoding constants, state enum and flag bit indices in shared package alu_pkg.
REQ-029 SHALL implement the iterative multiplier as sub-module alu_mul_iter (start, operands, done, 2*WIDTH product), instantiated only under ALU_MUL_EN.

Verification
REQ-030 SHALL cover: WIDTH=8, ADD A=0xF0 B=0x20 -> Y=0x10, carry=1, zero=0, out_valid one cycle after accept.
REQ-031 SHALL cover: SUB A=5 B=5 -> Y=0, zero=1, carry=0; compare A=3 B=7 -> Y=0xFF, neg=1.
REQ-032 SHALL cover: MUL A=0xFF B=0xFF -> Y=0x01, Y_hi=0xFE, out_valid 9 cycles after accept, in_ready=0 during BUSY, in_valid ignored meanwhile.
REQ-033 SHALL cover: reset asserted mid-MUL -> outputs at reset values at once, no out_valid; following ADD 1+1 -> Y=2.
REQ-034 SHALL cover: STORE after XOR 0xAA^0x0F=0xA5 -> Y stays 0xA5, out_valid pulses; ALU_MUL_EN undefined: op 1110 -> Y=0, latency 1.
REQ-035 SHALL cover: WIDTH=16 SHL A=0x8001 -> Y=0x0002, carry=1.
